// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage conditional branch resolution with registered outcome,
// mispredict detection, redirect PC, saturating branch/mispredict counters and an optional
// 2-bit saturating-counter BHT read combinationally by IF.
// Optional feature macro: BRANCH_PREDICTOR_EN (defined: BHT present; undefined: static
// not-taken prediction, no BHT).
module branch_resolve_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BHT_LOG2 = 6
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iFetchPC,
  output logic            oPredTaken,
  input  logic            iValid,
  input  logic            iFlush,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic [XLEN-1:0] iPC,
  input  logic [XLEN-1:0] iImm,
  input  logic            iPredTaken,
  output logic            oResolveValid,
  output logic            oTaken,
  output logic            oMispredict,
  output logic [XLEN-1:0] oRedirectPC,
  output logic [31:0]     oBranchCount,
  output logic [31:0]     oMispredictCount
);

  localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

  logic            accept;
  logic            legal;
  logic            cond;
  logic            taken_d;
  logic            mispredict_d;
  logic [XLEN-1:0] redirect_d;

  logic            resolve_valid_q;
  logic            taken_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;
  logic [31:0]     branch_cnt_q;
  logic [31:0]     mispredict_cnt_q;

  // Decode funct3 and evaluate the branch condition; 010/011 are illegal.
  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (iFunct3)
      3'b000:  cond = (iA == iB);
      3'b001:  cond = (iA != iB);
      3'b100:  cond = ($signed(iA) < $signed(iB));
      3'b101:  cond = ($signed(iA) >= $signed(iB));
      3'b110:  cond = (iA < iB);
      3'b111:  cond = (iA >= iB);
      default: legal = 1'b0;
    endcase
  end

  assign accept       = iValid & ~iFlush;
  assign taken_d      = legal & cond;
  // Illegal funct3 forces not-taken, so mispredict collapses to the prediction itself.
  assign mispredict_d = taken_d ^ iPredTaken;
  assign redirect_d   = taken_d ? (iPC + iImm) : (iPC + XLEN'(4));

  // Result register: valid pulses per accept, payload holds between accepts.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      resolve_valid_q <= 1'b0;
      taken_q         <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_q      <= '0;
    end else begin
      resolve_valid_q <= accept;
      if (accept) begin
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        redirect_q   <= redirect_d;
      end
    end
  end

  // Saturating statistics counters; only legal accepted branches count.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (accept && legal) begin
      if (branch_cnt_q != CntMax) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispredict_d && (mispredict_cnt_q != CntMax)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_EN
  localparam int unsigned BhtEntries = 1 << BHT_LOG2;

  logic [1:0]          bht_q [BhtEntries];
  logic [BHT_LOG2-1:0] lookup_idx;
  logic [BHT_LOG2-1:0] update_idx;

  assign lookup_idx = iFetchPC[BHT_LOG2+1:2];
  assign update_idx = iPC[BHT_LOG2+1:2];
  // Reads pre-edge contents, so a same-index update this cycle is not forwarded.
  assign oPredTaken = bht_q[lookup_idx][1];

  // BHT update: saturating increment on taken, decrement on not-taken.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bht_q <= '{default: 2'b01};
    end else if (accept && legal) begin
      if (taken_d) begin
        if (bht_q[update_idx] != 2'b11) begin
          bht_q[update_idx] <= bht_q[update_idx] + 2'd1;
        end
      end else begin
        if (bht_q[update_idx] != 2'b00) begin
          bht_q[update_idx] <= bht_q[update_idx] - 2'd1;
        end
      end
    end
  end
`else
  assign oPredTaken = 1'b0;
`endif

  // Only a slice of the PCs feeds the BHT index; the rest is intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{iFetchPC, iPC};

  assign oResolveValid    = resolve_valid_q;
  assign oTaken           = taken_q;
  assign oMispredict      = mispredict_q;
  assign oRedirectPC      = redirect_q;
  assign oBranchCount     = branch_cnt_q;
  assign oMispredictCount = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected results pushed at drive
// time, popped and compared one cycle later. Honours BRANCH_PREDICTOR_EN for prediction checks.
module tb_branch_resolve_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iFetchPC;
  logic        oPredTaken;
  logic        iValid;
  logic        iFlush;
  logic [2:0]  iFunct3;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [31:0] iPC;
  logic [31:0] iImm;
  logic        iPredTaken;
  logic        oResolveValid;
  logic        oTaken;
  logic        oMispredict;
  logic [31:0] oRedirectPC;
  logic [31:0] oBranchCount;
  logic [31:0] oMispredictCount;

  branch_resolve_unit #(
    .XLEN     (32),
    .BHT_LOG2 (6)
  ) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iFetchPC         (iFetchPC),
    .oPredTaken       (oPredTaken),
    .iValid           (iValid),
    .iFlush           (iFlush),
    .iFunct3          (iFunct3),
    .iA               (iA),
    .iB               (iB),
    .iPC              (iPC),
    .iImm             (iImm),
    .iPredTaken       (iPredTaken),
    .oResolveValid    (oResolveValid),
    .oTaken           (oTaken),
    .oMispredict      (oMispredict),
    .oRedirectPC      (oRedirectPC),
    .oBranchCount     (oBranchCount),
    .oMispredictCount (oMispredictCount)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_bht [64];
  logic        m_taken;
  logic        m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_bc;
  logic [31:0] m_mc;
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_taken = 1'b0;
    m_mis   = 1'b0;
    m_redir = 32'h0;
    m_bc    = 32'h0;
    m_mc    = 32'h0;
  endtask

  function automatic logic model_pred(input logic [31:0] fpc);
`ifdef BRANCH_PREDICTOR_EN
    logic [1:0] e;
    e = m_bht[fpc[7:2]];
    return e[1];
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of stimulus at posedge+1, check the combinational prediction, push the
  // expected registered result, then compare after the next edge.
  task automatic step(input logic v, input logic fl, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] imm, input logic pred, input logic [31:0] fpc);
    logic acc;
    logic lg;
    logic cnd;
    logic tk;
    exp_t e;
    exp_t got;
    iValid = v; iFlush = fl; iFunct3 = f3; iA = a; iB = b;
    iPC = pc; iImm = imm; iPredTaken = pred; iFetchPC = fpc;
    #1;
    check_eq("pred_taken", {31'b0, oPredTaken}, {31'b0, model_pred(fpc)});
    acc = v && !fl;
    lg  = 1'b1;
    cnd = 1'b0;
    case (f3)
      3'd0: cnd = (a == b);
      3'd1: cnd = (a != b);
      3'd4: cnd = (int'(a) < int'(b));
      3'd5: cnd = !(int'(a) < int'(b));
      3'd6: cnd = (a < b);
      3'd7: cnd = !(a < b);
      default: lg = 1'b0;
    endcase
    tk = lg && cnd;
    if (acc) begin
      m_taken = tk;
      m_mis   = (tk != pred);
      m_redir = tk ? pc + imm : pc + 32'd4;
      if (lg) begin
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
        if (tk != pred && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
        if (tk && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 1;
        if (!tk && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 1;
      end
    end
    e.valid = acc; e.taken = m_taken; e.mis = m_mis;
    e.redir = m_redir; e.bc = m_bc; e.mc = m_mc;
    exp_q.push_back(e);
    @(posedge iCLK);
    #1;
    got = exp_q.pop_front();
    check_eq("resolve_valid", {31'b0, oResolveValid}, {31'b0, got.valid});
    check_eq("taken", {31'b0, oTaken}, {31'b0, got.taken});
    check_eq("mispredict", {31'b0, oMispredict}, {31'b0, got.mis});
    check_eq("redirect_pc", oRedirectPC, got.redir);
    check_eq("branch_count", oBranchCount, got.bc);
    check_eq("mispredict_count", oMispredictCount, got.mc);
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, fpc);
  endtask

  initial begin
    // Reset asserted alongside an accept: reset must win.
    iRST = 1'b1; iValid = 1'b1; iFlush = 1'b0; iFunct3 = 3'd0; iA = 32'd5; iB = 32'd5;
    iPC = 32'h100; iImm = 32'h20; iPredTaken = 1'b0; iFetchPC = 32'h0;
    model_reset();
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    check_eq("rst_valid", {31'b0, oResolveValid}, 32'd0);
    check_eq("rst_taken", {31'b0, oTaken}, 32'd0);
    check_eq("rst_mis", {31'b0, oMispredict}, 32'd0);
    check_eq("rst_redirect", oRedirectPC, 32'd0);
    check_eq("rst_bcount", oBranchCount, 32'd0);
    check_eq("rst_mcount", oMispredictCount, 32'd0);

    // BEQ taken, predicted not-taken.
    step(1, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h0);
    // Signed vs unsigned less-than on the same operands.
    step(1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h0);
    step(1, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1, 32'h0);
    // Three taken BNE at index 16, prediction walks 01->10->11->11.
    repeat (3) step(1, 0, 3'd1, 32'd1, 32'd2, 32'h40, 32'hFFFF_FFF8, 0, 32'h40);
    idle(32'h40);
    // Two not-taken BGE bring it back to 01.
    repeat (2) step(1, 0, 3'd5, 32'd1, 32'd2, 32'h40, 32'h8, 1, 32'h40);
    idle(32'h40);
    // Same-cycle lookup and update at index 3.
    step(1, 0, 3'd7, 32'd5, 32'd3, 32'hC, 32'h100, 0, 32'hC);
    idle(32'hC);
    // Flushed branch and illegal funct3: no table or counter change.
    step(1, 1, 3'd0, 32'd7, 32'd7, 32'h80, 32'h40, 0, 32'h80);
    step(1, 0, 3'd2, 32'd7, 32'd7, 32'h80, 32'h40, 0, 32'h80);
    step(1, 0, 3'd3, 32'd7, 32'd8, 32'h80, 32'h40, 1, 32'h80);
    idle(32'h80);
    // Signed/unsigned GE with the sign bit set.
    step(1, 0, 3'd5, 32'h8000_0000, 32'd0, 32'h300, 32'h40, 1, 32'h300);
    step(1, 0, 3'd7, 32'h8000_0000, 32'd0, 32'h300, 32'h40, 1, 32'h300);

    // Mixed random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
           3'($urandom_range(0, 7)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
           {24'h0, 6'($urandom_range(0, 7)), 2'b00}, 32'($urandom), 1'($urandom_range(0, 1)),
           {24'h0, 6'($urandom_range(0, 7)), 2'b00});
    end

    // Branch counter saturation.
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    m_bc = 32'hFFFF_FFFE;
    check_eq("forced_bcount", oBranchCount, 32'hFFFF_FFFE);
    step(1, 0, 3'd0, 32'd1, 32'd1, 32'h500, 32'h4, 1, 32'h0);
    step(1, 0, 3'd0, 32'd1, 32'd1, 32'h500, 32'h4, 1, 32'h0);
    check_eq("bcount_saturated", oBranchCount, 32'hFFFF_FFFF);
    // Redirect wrap-around on a not-taken branch at the top of the address space.
    step(1, 0, 3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h10, 0, 32'h0);
    check_eq("wrap_redirect", oRedirectPC, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
